bw_seq_multiplier: RTL and testbench

- Sequential signed N×N Baugh-Wooley multiplier.
- Consumes one partial-product row per clock through a ripple row of full adders and accumulates the 2N-bit product.
- Sits directly upstream of the full_adder array. It generates the Baugh-Wooley partial-product rows, including the inverted sign terms and correction constants, and drives them into a row of full adders.
- Valid/ready handshakes on both operand input and product output. Trades area for N-cycle latency against the combinational array.

---
 rtl/bw_seq_multiplier_pkg.sv | 16 +
 rtl/bw_seq_multiplier_if.sv | 23 ++
 rtl/bw_seq_multiplier_row_adder.sv | 46 ++++
 rtl/bw_seq_multiplier.sv | 121 ++++++++++++
 tb/tb_bw_seq_multiplier.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/bw_seq_multiplier_pkg.sv
// Shared types and constants for the sequential Baugh-Wooley multiplier.
// Holds the FSM state encoding and the correction-constant helper.
package bw_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Baugh-Wooley correction constant 2^n + 2^(2n-1); valid for n <= 32.
  function automatic logic [63:0] bw_corr(input int unsigned n);
    bw_corr = (64'd1 << n) | (64'd1 << (2 * n - 1));
  endfunction

endpackage

// File: rtl/bw_seq_multiplier_if.sv
// Operand/product handshake bundle for bw_seq_multiplier.
// master = operand producer / product consumer, slave = multiplier.
interface bw_seq_multiplier_if #(
  parameter int N = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/bw_seq_multiplier_row_adder.sv
// Purpose: 2N-bit ripple adder (full_adder chain) folding one shifted row into the accumulator.
// Latency: combinational; carry out of the top bit is dropped (modulo 2^W).
// Backpressure: none, pure datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic Cout
);
  assign sum  = a ^ b ^ cin;
  assign Cout = (a & b) | (a & cin) | (b & cin);
endmodule

module bw_row_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] s
);
  logic [W-1:0] c;
  logic         cout_unused;

  assign c[0] = 1'b0;

  for (genvar k = 0; k < W; k++) begin : g_fa
    if (k < W - 1) begin : g_mid
      full_adder u_fa (
        .a   (x[k]),
        .b   (y[k]),
        .cin (c[k]),
        .sum (s[k]),
        .Cout(c[k+1])
      );
    end else begin : g_top
      full_adder u_fa (
        .a   (x[k]),
        .b   (y[k]),
        .cin (c[k]),
        .sum (s[k]),
        .Cout(cout_unused)
      );
    end
  end
endmodule

// File: rtl/bw_seq_multiplier.sv
// Purpose: sequential signed NxN Baugh-Wooley multiplier, one partial-product row per clock.
// Latency: out_valid N+1 cycles after accept (1 cycle for a zero operand with BW_SEQ_EARLY_ZERO_EN).
// Backpressure: product held in DONE until out_ready; in_ready only in IDLE.
module bw_seq_multiplier
  import bw_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  bw_seq_multiplier_if.slave   bus,
  output logic                 busy
);

  localparam logic [2*N-1:0] CORR = (2 * N)'(bw_corr(N));
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, b_q;
  logic [2*N-1:0]  acc_q;
  logic [CW-1:0]   row_q;
  logic [N-1:0]    row_bits;
  logic [2*N-1:0]  row_sh;
  logic [2*N-1:0]  acc_sum;
  logic            in_ready_c, out_valid_c, busy_c;
  logic            zero_op;

  assign zero_op = (bus.a == '0) || (bus.b == '0);

  // Sign-weighted terms (exactly one index at N-1) enter inverted.
  always_comb begin
    row_bits = '0;
    for (int i = 0; i < N; i++) begin
      row_bits[i] = (a_q[i] & b_q[row_q]) ^ ((i == N - 1) != (row_q == LAST));
    end
  end

  assign row_sh = {{N{1'b0}}, row_bits} << row_q;

  bw_row_adder #(.W(2 * N)) u_row_adder (
    .x(acc_q),
    .y(row_sh),
    .s(acc_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
`ifdef BW_SEQ_EARLY_ZERO_EN
          state_d = zero_op ? S_DONE : S_CALC;
`else
          state_d = S_CALC;
`endif
        end
      end
      S_CALC: begin
        busy_c = 1'b1;
        if (row_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      row_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            row_q <= '0;
`ifdef BW_SEQ_EARLY_ZERO_EN
            acc_q <= zero_op ? '0 : CORR;
`else
            acc_q <= CORR;
`endif
          end
        end
        S_CALC: begin
          acc_q <= acc_sum;
          row_q <= (row_q == LAST) ? '0 : row_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // The operand-zero test only matters to the early-exit build.
  logic zero_op_unused;
  assign zero_op_unused = zero_op;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.product   = acc_q;
  assign busy          = busy_c;

endmodule

// File: tb/tb_bw_seq_multiplier.sv
// Directed and random checks of bw_seq_multiplier (N=8), including backpressure and mid-op reset.
module tb_bw_seq_multiplier;
  localparam int N = 8;
`ifdef BW_SEQ_EARLY_ZERO_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = N + 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  bw_seq_multiplier_if #(.N(N)) bus ();

  bw_seq_multiplier #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns product and the cycle on which out_valid was first seen.
  task automatic transact(input logic [7:0] x, input logic [7:0] y,
                          output logic [15:0] p, output int lat);
    int w;
    w = 0;
    while (!bus.in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    p = bus.product;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = '0;
    bus.b = '0;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (bus.product !== 16'h0000) begin bad++; $display("FAIL rst_product: got %h want 0000", bus.product); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flags();
    int w;
    bus.out_ready = 1'b1;
    bus.a = 8'd5;
    bus.b = 8'hFD;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL calc_busy: got %b want 1", busy); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL calc_in_ready: got %b want 0", bus.in_ready); end
    w = 0;
    while (!bus.out_valid && w < 40) begin @(negedge clk); w++; end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL flags_timeout: out_valid got %b want 1", bus.out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_busy: got %b want 0", busy); end
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [7:0]  va [8];
    logic [7:0]  vb [8];
    logic [15:0] ve [8];
    logic [15:0] p;
    int lat, el;
    va = '{8'd5, 8'h80, 8'd127, 8'hFF, 8'd0,  8'd127, 8'd3, 8'h80};
    vb = '{8'hFD, 8'h80, 8'h80, 8'hFF, 8'hB3, 8'd127, 8'd0, 8'd127};
    ve = '{16'hFFF1, 16'h4000, 16'hC080, 16'h0001, 16'h0000, 16'h3F01, 16'h0000, 16'hC080};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      transact(va[k], vb[k], p, lat);
      el = (va[k] == 8'd0 || vb[k] == 8'd0) ? ZERO_LAT : N + 1;
      total++; if (p !== ve[k]) begin bad++; $display("FAIL vec%0d_product: got %h want %h", k, p, ve[k]); end
      total++; if (lat != el) begin bad++; $display("FAIL vec%0d_latency: got %0d want %0d", k, lat, el); end
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL vec%0d_pulse: out_valid got %b want 0", k, bus.out_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] p;
    int lat;
    bus.out_ready = 1'b0;
    transact(8'd12, 8'd10, p, lat);
    total++; if (p !== 16'h0078) begin bad++; $display("FAIL bp_product: got %h want 0078", p); end
    total++; if (lat != N + 1) begin bad++; $display("FAIL bp_latency: got %0d want %0d", lat, N + 1); end
    bus.a = 8'h55;
    bus.b = 8'h22;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (bus.product !== 16'h0078) begin bad++; $display("FAIL bp_hold%0d: got %h want 0078", k, bus.product); end
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d: got %b want 1", k, bus.out_valid); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d: got %b want 0", k, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] p;
    int lat, seen;
    bus.out_ready = 1'b1;
    bus.a = 8'd100;
    bus.b = 8'd100;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready: got %b want 1", bus.in_ready); end
    total++; if (bus.product !== 16'h0000) begin bad++; $display("FAIL mid_product: got %h want 0000", bus.product); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_no_pulse: out_valid cycles got %0d want 0", seen); end
    transact(8'd2, 8'd3, p, lat);
    total++; if (p !== 16'h0006) begin bad++; $display("FAIL mid_next_product: got %h want 0006", p); end
    total++; if (lat != N + 1) begin bad++; $display("FAIL mid_next_latency: got %0d want %0d", lat, N + 1); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int w, g;
    bus.out_ready = 1'b1;
    bus.a = 8'd3;
    bus.b = 8'd7;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.out_valid && w < 40) begin @(negedge clk); w++; end
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!bus.out_valid && g < 40);
    bus.in_valid = 1'b0;
    total++; if (g != N + 2) begin bad++; $display("FAIL b2b_period: got %0d want %0d", g, N + 2); end
    total++; if (bus.product !== 16'h0015) begin bad++; $display("FAIL b2b_product: got %h want 0015", bus.product); end
    w = 0;
    while (!bus.in_ready && w < 40) begin @(negedge clk); w++; end
  endtask

  task automatic test_random();
    logic [7:0]        x, y;
    logic signed [7:0] sx, sy;
    logic [15:0]       e, p;
    int lat;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      sx = x;
      sy = y;
      e = sx * sy;
      transact(x, y, p, lat);
      total++; if (p !== e || lat < 0) begin bad++; $display("FAIL rand%0d: %h*%h got %h want %h", k, x, y, p, e); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_flags();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
